turbo_cb_assembler: RTL

//  Upstream stage of coder_interleaver. Collects a byte stream into one turbo code block
//  (K = 1056 or 6144 bits) and presents it as a parallel word with a K-size flag.

---
 rtl/turbo_pkg.sv | 18 +
 rtl/cb_byte_counter.sv | 41 ++++
 rtl/turbo_cb_assembler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/turbo_pkg.sv
// Shared constants and state encoding for the turbo code-block front end.
// Both block sizes are whole numbers of bytes, so the counter never sees a partial byte.
package turbo_pkg;

  localparam int BYTE_W      = 8;
  localparam int K_LARGE     = 6144;
  localparam int K_SMALL     = 1056;
  localparam int BYTES_LARGE = K_LARGE / BYTE_W;  // 768
  localparam int BYTES_SMALL = K_SMALL / BYTE_W;  // 132
  localparam int CNT_W       = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

endpackage

// File: rtl/cb_byte_counter.sv
// Byte slot counter for the block being filled. It can be cleared, loaded with 1 or
// incremented, and it flags the final slot of the selected block size.
module cb_byte_counter #(
  parameter int CNT_W   = turbo_pkg::CNT_W,
  parameter int N_LARGE = turbo_pkg::BYTES_LARGE,
  parameter int N_SMALL = turbo_pkg::BYTES_SMALL
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load_one,
  input  logic             inc,
  input  logic             k6144,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             last_byte
);
  import turbo_pkg::*;

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (load_one)
      cnt_next = CNT_W'(1);
    else if (inc)
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign byte_cnt  = cnt_reg;
  assign last_byte = (cnt_reg == (k6144 ? CNT_W'(N_LARGE - 1) : CNT_W'(N_SMALL - 1)));

endmodule

// File: rtl/turbo_cb_assembler.sv
// Packs a byte stream into one turbo code block (K = 1056 or 6144) and hands it to the
// interleaver through a double buffer: a fill register plus a held output register.
module turbo_cb_assembler #(
  parameter int BYTE_W  = turbo_pkg::BYTE_W,
  parameter int K_LARGE = turbo_pkg::K_LARGE,
  parameter int K_SMALL = turbo_pkg::K_SMALL
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_start,
  input  logic               in_k6144,
  output logic               in_ready,
  output logic [K_LARGE-1:0] cb_data,
  output logic               cb_k_eq_6144,
  output logic               cb_valid,
  input  logic               cb_ready,
  output logic               err_restart
);
  import turbo_pkg::*;

  localparam int N_LARGE = K_LARGE / BYTE_W;
  localparam int N_SMALL = K_SMALL / BYTE_W;

  state_e state_reg, state_next;

  logic               accept;
  logic               write_en;
  logic               restart;
  logic               cnt_clr;
  logic               cnt_load;
  logic               cnt_inc;
  logic               out_load;
  logic               err_next;
  logic               k_reg;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   wr_slot;
  logic               last_byte;
  logic [K_LARGE-1:0] fill_flat;
  logic [K_LARGE-1:0] cb_data_reg;
  logic               cb_k_reg;
  logic               cb_valid_reg;
  logic               err_restart_reg;

  // in_ready depends on state only, so cb_ready never reaches the input side combinationally.
  assign in_ready = (state_reg != FULL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    write_en   = 1'b0;
    restart    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    out_load   = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_start) begin
            write_en   = 1'b1;
            restart    = 1'b1;
            cnt_load   = 1'b1;
            state_next = FILL;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          write_en = 1'b1;
          if (in_start) begin
            restart  = 1'b1;
            cnt_load = 1'b1;
            err_next = 1'b1;
          end else if (last_byte) begin
            cnt_clr    = 1'b1;
            state_next = FULL;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      FULL: begin
        if (!cb_valid_reg || cb_ready) begin
          out_load   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  cb_byte_counter #(
    .CNT_W   (CNT_W),
    .N_LARGE (N_LARGE),
    .N_SMALL (N_SMALL)
  ) u_byte_counter (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (cnt_clr),
    .load_one  (cnt_load),
    .inc       (cnt_inc),
    .k6144     (k_reg),
    .byte_cnt  (byte_cnt),
    .last_byte (last_byte)
  );

  // A start byte always lands in slot 0 and wipes every other slot of the previous block.
  assign wr_slot = restart ? '0 : byte_cnt;

  for (genvar gi = 0; gi < N_LARGE; gi++) begin : g_byte
    logic              byte_we;
    logic [BYTE_W-1:0] byte_reg;

    assign byte_we = write_en && (wr_slot == CNT_W'(gi));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
        byte_reg <= '0;
      else if (byte_we)
        byte_reg <= in_data;
      else if (restart)
        byte_reg <= '0;
    end

    assign fill_flat[gi*BYTE_W +: BYTE_W] = byte_reg;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      k_reg <= 1'b0;
    else if (restart)
      k_reg <= in_k6144;
  end

  // Load wins over handshake, so back-to-back blocks keep cb_valid high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cb_data_reg     <= '0;
      cb_k_reg        <= 1'b0;
      cb_valid_reg    <= 1'b0;
      err_restart_reg <= 1'b0;
    end else begin
      err_restart_reg <= err_next;
      if (out_load) begin
        cb_data_reg  <= fill_flat;
        cb_k_reg     <= k_reg;
        cb_valid_reg <= 1'b1;
      end else if (cb_ready) begin
        cb_valid_reg <= 1'b0;
      end
    end
  end

  assign cb_data      = cb_data_reg;
  assign cb_k_eq_6144 = cb_k_reg;
  assign cb_valid     = cb_valid_reg;
  assign err_restart  = err_restart_reg;

endmodule
